// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader
//   Scans the nine time/date/timer registers of the external RTC over its
//   multiplexed AD bus. Results go to output registers read by the PicoBlaze
//   input mux. The nine outputs only change together, in COMMIT.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start             one-cycle scan request (honoured only in IDLE)
//   ad_in             AD bus input side
//   ad_out, ad_oe     AD bus drive value and drive enable
//   cs_n, rd_n, wr_n  RTC chip select / read / write strobes (active low)
//   a_d_n             0 = address cycle, 1 = data cycle
//   busy, done        scan in progress / one-cycle completion pulse
//   *_rtc             BCD register values as read from the RTC
module rtc_bus_reader #(
    parameter int T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg_rtc,
    output logic [7:0] min_rtc,
    output logic [7:0] hora_rtc,
    output logic [7:0] dia_rtc,
    output logic [7:0] mes_rtc,
    output logic [7:0] year_rtc,
    output logic [7:0] seg_tim_rtc,
    output logic [7:0] min_tim_rtc,
    output logic [7:0] hora_tim_rtc
);

    typedef enum logic [2:0] {
        IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, COMMIT
    } state_t;

    localparam logic [7:0] RELOAD = 8'(T_PHASE - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] idx;
    logic [7:0] shadow [9];
    logic       last;

    assign last = (cnt == 8'd0);

    // Indices 0..5 map to 0x21..0x26, indices 6..8 to 0x41..0x43.
    function automatic logic [7:0] addr_of(input logic [3:0] i);
        return (i < 4'd6) ? (8'h21 + {4'h0, i}) : (8'h3b + {4'h0, i});
    endfunction

    // Outputs are registered: each transition loads the bus/strobe values
    // belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            idx    <= 4'd0;
            ad_out <= 8'h00;
            ad_oe  <= 1'b0;
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d_n  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < 9; i++) shadow[i] <= 8'h00;
            seg_rtc      <= 8'h00;
            min_rtc      <= 8'h00;
            hora_rtc     <= 8'h00;
            dia_rtc      <= 8'h00;
            mes_rtc      <= 8'h00;
            year_rtc     <= 8'h00;
            seg_tim_rtc  <= 8'h00;
            min_tim_rtc  <= 8'h00;
            hora_tim_rtc <= 8'h00;
        end else begin
            // Phase timer; every phase transition below reloads it.
            if (state != IDLE && state != COMMIT) cnt <= cnt - 8'd1;

            case (state)
                IDLE: if (start) begin
                    state  <= A_SET;
                    cnt    <= RELOAD;
                    idx    <= 4'd0;
                    busy   <= 1'b1;
                    cs_n   <= 1'b0;
                    a_d_n  <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= addr_of(4'd0);
                end
                A_SET: if (last) begin
                    state <= A_STB;
                    cnt   <= RELOAD;
                    wr_n  <= 1'b0;
                end
                A_STB: if (last) begin
                    state <= A_HLD;
                    cnt   <= RELOAD;
                    wr_n  <= 1'b1;
                end
                A_HLD: if (last) begin
                    // Release the bus a full phase before rd_n falls.
                    state  <= D_SET;
                    cnt    <= RELOAD;
                    ad_oe  <= 1'b0;
                    ad_out <= 8'h00;
                    a_d_n  <= 1'b1;
                end
                D_SET: if (last) begin
                    state <= D_STB;
                    cnt   <= RELOAD;
                    rd_n  <= 1'b0;
                end
                D_STB: if (last) begin
                    state       <= D_HLD;
                    cnt         <= RELOAD;
                    shadow[idx] <= ad_in;
                    rd_n        <= 1'b1;
                    cs_n        <= 1'b1;
                end
                D_HLD: if (last) begin
                    if (idx == 4'd8) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end else begin
                        state  <= A_SET;
                        cnt    <= RELOAD;
                        idx    <= idx + 4'd1;
                        cs_n   <= 1'b0;
                        a_d_n  <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= addr_of(idx + 4'd1);
                    end
                end
                COMMIT: begin
                    state        <= IDLE;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    seg_rtc      <= shadow[0];
                    min_rtc      <= shadow[1];
                    hora_rtc     <= shadow[2];
                    dia_rtc      <= shadow[3];
                    mes_rtc      <= shadow[4];
                    year_rtc     <= shadow[5];
                    seg_tim_rtc  <= shadow[6];
                    min_tim_rtc  <= shadow[7];
                    hora_tim_rtc <= shadow[8];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Testbench for rtc_bus_reader: one instance at T_PHASE=4 (lane 0) and one at
// T_PHASE=1 (lane 1), each attached to a behavioural RTC model (256-byte
// register file addressed by the byte latched during the write strobe).
module tb_rtc_bus_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start, reset, ad_oe, cs_n, rd_n, wr_n, a_d_n, busy, done;
    logic [7:0] ad_out [2];
    logic [7:0] ad_in  [2];
    logic [7:0] obs    [2][9];
    logic [7:0] mem    [2][256];
    logic [7:0] cur    [2][9];
    logic [7:0] addrs  [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                               8'h41, 8'h42, 8'h43};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int T = (g == 0) ? 4 : 1;
        logic [7:0] lat;

        rtc_bus_reader #(.T_PHASE(T)) dut (
            .clk(clk), .reset(reset[g]), .start(start[g]), .ad_in(ad_in[g]),
            .ad_out(ad_out[g]), .ad_oe(ad_oe[g]), .cs_n(cs_n[g]),
            .rd_n(rd_n[g]), .wr_n(wr_n[g]), .a_d_n(a_d_n[g]),
            .busy(busy[g]), .done(done[g]),
            .seg_rtc(obs[g][0]), .min_rtc(obs[g][1]), .hora_rtc(obs[g][2]),
            .dia_rtc(obs[g][3]), .mes_rtc(obs[g][4]), .year_rtc(obs[g][5]),
            .seg_tim_rtc(obs[g][6]), .min_tim_rtc(obs[g][7]),
            .hora_tim_rtc(obs[g][8])
        );

        // RTC model: latch address on write strobe, drive data during read.
        always @(posedge clk) if (!cs_n[g] && !wr_n[g]) lat <= ad_out[g];
        assign ad_in[g] = !rd_n[g] ? mem[g][lat] : 8'hee;

        // Bus protocol monitor; its run state is cleared whenever idle.
        int   wr_len, rd_len, oe0_len, seq;
        logic wr_p, rd_p;
        always @(negedge clk) begin
            if (!busy[g]) begin
                wr_len = 0; rd_len = 0; oe0_len = 0; seq = 0;
                wr_p = 1'b1; rd_p = 1'b1;
            end else begin
                if (!wr_n[g]) chk("wr_bus", {ad_oe[g], a_d_n[g]}, 2'b10);
                if (!rd_n[g]) chk("rd_bus", ad_oe[g], 0);
                if (wr_p && !wr_n[g]) begin
                    chk("addr_order", ad_out[g], addrs[seq]);
                    seq = (seq == 8) ? 0 : seq + 1;
                end
                if (rd_p && !rd_n[g]) chk("turnaround", oe0_len >= T, 1);
                if (!wr_p && wr_n[g]) chk("wr_width", wr_len, T);
                if (!rd_p && rd_n[g]) chk("rd_width", rd_len, T);
                wr_len  = wr_n[g] ? 0 : wr_len + 1;
                rd_len  = rd_n[g] ? 0 : rd_len + 1;
                oe0_len = ad_oe[g] ? 0 : oe0_len + 1;
                wr_p = wr_n[g];
                rd_p = rd_n[g];
            end
        end
    end

    task automatic rand_mem(input int g);
        for (int i = 0; i < 9; i++) mem[g][addrs[i]] = 8'($urandom);
    endtask

    task automatic chk_idle(input int g, input string tag);
        chk({tag, "_oe"}, ad_oe[g], 0);
        chk({tag, "_strobes"}, {cs_n[g], rd_n[g], wr_n[g], a_d_n[g]}, 4'hf);
        chk({tag, "_busy_done"}, {busy[g], done[g]}, 2'b00);
        for (int i = 0; i < 9; i++) chk({tag, "_data"}, obs[g][i], 0);
    endtask

    // One scan on lane g, entered at a negedge. Optional extra start pulses
    // (x1, x2), a model change of 0x21 (chg_cyc), and a reset (rst_cyc);
    // -1 disables each. Cycle c is the period following edge c-1.
    task automatic scan(input int g, input int x1, input int x2,
                        input int chg_cyc, input logic [7:0] chg_val,
                        input int rst_cyc);
        int T = (g == 0) ? 4 : 1;
        int n = 54 * T + 2;
        int n_done = 0;
        int done_cyc = -1;
        logic [7:0] exp [9];
        for (int i = 0; i < 9; i++) exp[i] = mem[g][addrs[i]];
        start[g] = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= n; c++) begin
            start[g] = (c == x1 || c == x2);
            if (c == chg_cyc) mem[g][8'h21] = chg_val;
            if (done[g]) begin n_done++; done_cyc = c; end
            if (c == 1) chk("busy_start", busy[g], 1);
            if (c == rst_cyc) begin
                reset[g] = 1'b0;
                @(negedge clk);
                chk_idle(g, "reset_mid");
                chk("reset_no_done", n_done, 0);
                reset[g] = 1'b1;
                for (int i = 0; i < 9; i++) cur[g][i] = 8'h00;
                return;
            end
            if (c == n - 1)
                for (int i = 0; i < 9; i++) chk("hold_until_commit", obs[g][i], cur[g][i]);
            if (c == n) begin
                for (int i = 0; i < 9; i++) chk("commit_data", obs[g][i], exp[i]);
                chk("busy_end", busy[g], 0);
            end
            if (c < n) @(negedge clk);
        end
        chk("done_count", n_done, 1);
        chk("done_cycle", done_cyc, 54 * T + 1);
        for (int i = 0; i < 9; i++) cur[g][i] = exp[i];
    endtask

    initial begin
        logic [7:0] vals [9] = '{8'h59, 8'h58, 8'h23, 8'h31, 8'h12, 8'h99,
                                 8'h10, 8'h20, 8'h05};
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 256; a++) mem[g][a] = 8'h00;
            for (int i = 0; i < 9; i++) cur[g][i] = 8'h00;
        end
        start = 2'b00;
        reset = 2'b00;
        repeat (3) @(negedge clk);
        chk_idle(0, "reset");
        chk_idle(1, "reset");
        reset = 2'b11;

        // Lane 0, T_PHASE=4: directed values.
        for (int i = 0; i < 9; i++) mem[0][addrs[i]] = vals[i];
        scan(0, -1, -1, -1, 8'h00, -1);
        // Coherency: 0x21 changes after it has been read.
        mem[0][8'h21] = 8'h10;
        scan(0, -1, -1, 40, 8'h11, -1);
        chk("coherent_first", obs[0][0], 8'h10);
        scan(0, -1, -1, -1, 8'h00, -1);
        chk("coherent_second", obs[0][0], 8'h11);
        // Start while busy is ignored.
        rand_mem(0);
        scan(0, 5, 100, -1, 8'h00, -1);
        // Reset mid-scan, then a normal scan.
        rand_mem(0);
        scan(0, -1, -1, -1, 8'h00, 120);
        rand_mem(0);
        scan(0, -1, -1, -1, 8'h00, -1);

        // Lane 1, T_PHASE=1.
        rand_mem(1);
        scan(1, -1, -1, -1, 8'h00, -1);
        rand_mem(1);
        scan(1, -1, -1, -1, 8'h00, 30);
        rand_mem(1);
        scan(1, -1, -1, -1, 8'h00, -1);
        rand_mem(1);
        scan(1, 5, 20, -1, 8'h00, -1);

        start = 2'b00;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
